// File: rtl/filter_pkg.sv
// Shared constants and types for the filter_engine image stage.
package filter_pkg;

  localparam int IMG_W_DEF  = 100;
  localparam int IMG_H_DEF  = 100;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 14;

  // cycles from a complete window to the res_* registers, both functions
  localparam int P = 3;

  localparam logic FUNC_MEDIAN = 1'b0;
  localparam logic FUNC_SOBEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/filter_engine_median9.sv
// Three-stage 9-input median network: row sorts, then max/med/min of columns, then med3.
module median9
  import filter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9*DATA_W-1:0]   win,
  output logic [DATA_W-1:0]     med
);

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [DATA_W-1:0] lo_q [3];
  logic [DATA_W-1:0] mi_q [3];
  logic [DATA_W-1:0] hi_q [3];
  logic [DATA_W-1:0] max_lo_q, med_mi_q, min_hi_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        lo_q[g] <= '0;
        mi_q[g] <= '0;
        hi_q[g] <= '0;
      end
      max_lo_q <= '0;
      med_mi_q <= '0;
      min_hi_q <= '0;
      med      <= '0;
    end else begin
      for (int g = 0; g < 3; g++) begin
        lo_q[g] <= min2(min2(win[(3*g)*DATA_W +: DATA_W], win[(3*g+1)*DATA_W +: DATA_W]),
                        win[(3*g+2)*DATA_W +: DATA_W]);
        mi_q[g] <= med3(win[(3*g)*DATA_W +: DATA_W], win[(3*g+1)*DATA_W +: DATA_W],
                        win[(3*g+2)*DATA_W +: DATA_W]);
        hi_q[g] <= max2(max2(win[(3*g)*DATA_W +: DATA_W], win[(3*g+1)*DATA_W +: DATA_W]),
                        win[(3*g+2)*DATA_W +: DATA_W]);
      end
      max_lo_q <= max2(max2(lo_q[0], lo_q[1]), lo_q[2]);
      med_mi_q <= med3(mi_q[0], mi_q[1], mi_q[2]);
      min_hi_q <= min2(min2(hi_q[0], hi_q[1]), hi_q[2]);
      med      <= med3(max_lo_q, med_mi_q, min_hi_q);
    end
  end

endmodule

// File: rtl/filter_engine.sv
// Streams a source frame through a 3x3 window and writes a median or Sobel result per pixel.
//  state | meaning
//  IDLE  | waiting for start, func latched on acceptance
//  RUN   | issuing src_addr 0..N-1, one per cycle
//  FLUSH | feeding IMG_W+1 zero pixels, then draining the P-stage pipeline
//  DONE  | one-cycle done pulse
module filter_engine
  import filter_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              func,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done
);

  localparam int N         = IMG_W * IMG_H;
  localparam int FLUSH_LEN = IMG_W + P + 2;
  localparam int FW        = $clog2(FLUSH_LEN + 1);
  localparam int LW        = $clog2(IMG_W + 2);
  localparam int CW        = $clog2(IMG_W);
  localparam int RW        = $clog2(IMG_H);
  localparam int GW        = DATA_W + 3;
  localparam int MW        = GW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [MW-1:0]     SAT       = MW'((1 << DATA_W) - 1);

  state_t state_q, state_d;

  logic              func_q;
  logic [FW-1:0]     flush_cnt;
  logic [LW-1:0]     fill_cnt;
  logic              pix_v;
  logic              in_v;
  logic [DATA_W-1:0] in_px;
  logic              win_v;
  logic [RW-1:0]     cen_r;
  logic [CW-1:0]     cen_c;
  logic [ADDR_W-1:0] cen_a;
  logic              cen_border;

  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] col0 [3];
  logic [DATA_W-1:0] col1 [3];
  logic [DATA_W-1:0] p [3][3];
  logic [9*DATA_W-1:0] win_flat;

  logic              v1, v2, b1, b2, b3;
  logic [ADDR_W-1:0] a1, a2;
  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic [GW-1:0]     ax, ay;
  logic [MW-1:0]     mag_q;
  logic [DATA_W-1:0] sob_q, med_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (src_addr == LAST_ADDR) state_d = FLUSH;
      FLUSH:   if (flush_cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN) || (state_q == FLUSH);
  assign done = (state_q == DONE);

  // Real pixels arrive one cycle after their fetch; dummies fill the flush gap after the last one
  assign in_v  = pix_v || ((state_q == FLUSH) && (flush_cnt >= FW'(P)) && (flush_cnt <= FW'(IMG_W + P)));
  assign in_px = pix_v ? src_data : '0;
  assign win_v = in_v && (fill_cnt == '0);
  assign cen_border = (cen_r == '0) || (cen_r == RW'(IMG_H - 1)) ||
                      (cen_c == '0) || (cen_c == CW'(IMG_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      func_q    <= FUNC_MEDIAN;
      src_addr  <= '0;
      flush_cnt <= '0;
      fill_cnt  <= '0;
      pix_v     <= 1'b0;
      cen_r     <= '0;
      cen_c     <= '0;
      cen_a     <= '0;
    end else begin
      pix_v <= (state_q == RUN);
      if (state_q == IDLE && start) begin
        func_q   <= func;
        src_addr <= '0;
        fill_cnt <= LW'(IMG_W + 1);
        cen_r    <= '0;
        cen_c    <= '0;
        cen_a    <= '0;
      end else begin
        if (state_q == RUN && src_addr != LAST_ADDR) src_addr <= src_addr + 1'b1;
        if (in_v && fill_cnt != '0) fill_cnt <= fill_cnt - 1'b1;
        if (win_v) begin
          cen_a <= cen_a + 1'b1;
          if (cen_c == CW'(IMG_W - 1)) begin
            cen_c <= '0;
            cen_r <= cen_r + 1'b1;
          end else begin
            cen_c <= cen_c + 1'b1;
          end
        end
      end
      if (state_q == RUN && state_d == FLUSH) flush_cnt <= FW'(FLUSH_LEN - 1);
      else if (state_q == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
    end
  end

  // Line buffers and window are never cleared; border masking hides stale contents
  always_ff @(posedge clk) begin
    if (in_v) begin
      lb0[0] <= in_px;
      lb1[0] <= lb0[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb0[i] <= lb0[i-1];
        lb1[i] <= lb1[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        col0[r] <= col1[r];
        col1[r] <= p[r][2];
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      p[r][0] = col0[r];
      p[r][1] = col1[r];
    end
    p[0][2] = lb1[IMG_W-1];
    p[1][2] = lb0[IMG_W-1];
    p[2][2] = in_px;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_flat[(3*r+c)*DATA_W +: DATA_W] = p[r][c];
  end

  median9 #(.DATA_W(DATA_W)) u_median (
    .clk (clk),
    .rst (rst),
    .win (win_flat),
    .med (med_q)
  );

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] x);
    return $signed({{(GW-DATA_W){1'b0}}, x});
  endfunction

  always_comb begin
    gx_d = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2])) -
           (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
    gy_d = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2])) -
           (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
    ax   = gx_q[GW-1] ? -gx_q : gx_q;
    ay   = gy_q[GW-1] ? -gy_q : gy_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;  v2 <= 1'b0;  res_we   <= 1'b0;
      a1 <= '0;    a2 <= '0;    res_addr <= '0;
      b1 <= 1'b0;  b2 <= 1'b0;  b3       <= 1'b0;
      gx_q  <= '0;
      gy_q  <= '0;
      mag_q <= '0;
      sob_q <= '0;
    end else begin
      v1 <= win_v;  v2 <= v1;  res_we   <= v2;
      a1 <= cen_a;  a2 <= a1;  res_addr <= a2;
      b1 <= cen_border;  b2 <= b1;  b3 <= b2;
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      mag_q <= MW'(ax) + MW'(ay);
      sob_q <= (mag_q > SAT) ? SAT[DATA_W-1:0] : mag_q[DATA_W-1:0];
    end
  end

  assign res_data = b3 ? '0 : ((func_q == FUNC_SOBEL) ? sob_q : med_q);

endmodule

// File: tb/tb_filter_engine.sv
// Frame-level bench for filter_engine: ROM model, reference filter and write scoreboard.
module tb_filter_engine;
  localparam int W = 100;
  localparam int H = 100;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        func = 1'b0;
  logic [13:0] src_addr;
  logic [7:0]  src_data;
  logic        res_we;
  logic [13:0] res_addr;
  logic [7:0]  res_data;
  logic        busy;
  logic        done;

  filter_engine dut (
    .clk(clk), .rst(rst), .start(start), .func(func),
    .src_addr(src_addr), .src_data(src_data),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] img [N];
  always @(posedge clk) src_data <= img[src_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; } exp_t;
  exp_t sb[$];

  typedef struct { int pat; bit fn; int probe_a; int probe_v; } vec_t;
  vec_t vecs [6];

  int tests = 0;
  int failed = 0;
  int s_cyc = 0;
  int wr_cnt = 0;
  int probe_a = -1;
  int probe_got = -1;

  task automatic check(input string name, input int act, input int exp, input int ctx = -1);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s ctx=%0d: got %0d expected %0d", name, ctx, act, exp);
    end
  endtask

  task automatic load_image(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0: img[r*W+c] = 8'd50;
          1: img[r*W+c] = (c < 50) ? 8'd0 : 8'd200;
          2: img[r*W+c] = 8'(c);
          default: img[r*W+c] = (r == 10 && c == 10) ? 8'd255 : 8'd0;
        endcase
  endtask

  function automatic int model(input int a, input bit fn);
    int r, c, gx, gy, t;
    int q [3][3];
    int s [9];
    r = a / W;
    c = a % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        q[i][j] = int'(img[(r-1+i)*W + (c-1+j)]);
        s[3*i+j] = q[i][j];
      end
    if (fn) begin
      gx = (q[0][2] + 2*q[1][2] + q[2][2]) - (q[0][0] + 2*q[1][0] + q[2][0]);
      gy = (q[2][0] + 2*q[2][1] + q[2][2]) - (q[0][0] + 2*q[0][1] + q[0][2]);
      t = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (t > 255) ? 255 : t;
    end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  always @(negedge clk) begin
    if (res_we) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: got addr %0d expected no write", res_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", int'(res_addr), e.addr, e.addr);
        check("wr_data", int'(res_data), e.data, e.addr);
        check("wr_cycle", cyc - s_cyc, W + 6 + e.addr, e.addr);
        check("wr_busy", int'(busy), 1, e.addr);
        if (e.addr == probe_a) probe_got = int'(res_data);
        wr_cnt++;
      end
    end
  end

  task automatic run_frame(input int pat, input bit fn, input bit after_done, input bit poke,
                           input int pa, input int pv);
    bit seen;
    int guard;
    load_image(pat);
    for (int a = 0; a < N; a++) sb.push_back('{a, model(a, fn)});
    wr_cnt = 0;
    probe_a = pa;
    probe_got = -1;
    start = 1'b1;
    func = fn;
    if (after_done) begin
      @(negedge clk);
      s_cyc = cyc;
    end else begin
      s_cyc = cyc;
    end
    @(negedge clk);
    start = 1'b0;
    func = !fn;
    check("src_addr_first", int'(src_addr), 0, pat);
    check("busy_first", int'(busy), 1, pat);
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < N + 400) begin
      if (cyc == s_cyc + N) check("src_addr_last", int'(src_addr), N - 1, pat);
      if (cyc == s_cyc + N + 50) check("src_addr_hold", int'(src_addr), N - 1, pat);
      start = poke && (cyc == s_cyc + 3000);
      if (done) begin
        seen = 1'b1;
        check("done_cycle", cyc - s_cyc, N + W + 6, pat);
        check("write_count", wr_cnt, N, pat);
        check("sb_empty", sb.size(), 0, pat);
        check("busy_at_done", int'(busy), 0, pat);
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      tests++;
      failed++;
      $display("FAIL done_timeout: got no done expected done at +%0d", N + W + 6);
      sb.delete();
    end
    check("probe", probe_got, pv, pa);
  endtask

  initial begin
    int done_cnt;
    vecs[0] = '{0, 1'b0, 5050, 50};
    vecs[1] = '{0, 1'b1, 5050, 0};
    vecs[2] = '{1, 1'b1, 1049, 255};
    vecs[3] = '{2, 1'b1, 5050, 8};
    vecs[4] = '{2, 1'b0, 5037, 37};
    vecs[5] = '{3, 1'b0, 1010, 0};

    repeat (3) @(negedge clk);
    check("rst_src_addr", int'(src_addr), 0);
    check("rst_res_we", int'(res_we), 0);
    check("rst_res_addr", int'(res_addr), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].pat, vecs[i].fn, i > 0, i == 0, vecs[i].probe_a, vecs[i].probe_v);

    // mid-frame reset abort
    @(negedge clk);
    load_image(2);
    for (int a = 0; a < N; a++) sb.push_back('{a, model(a, 1'b1)});
    probe_a = -1;
    start = 1'b1;
    func = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s_cyc + 5000) @(negedge clk);
    check("pre_abort_writes_seen", int'(wr_cnt > 4000), 1);
    rst = 1'b0;
    #1;
    sb.delete();
    check("abort_src_addr", int'(src_addr), 0);
    check("abort_res_we", int'(res_we), 0);
    check("abort_res_addr", int'(res_addr), 0);
    check("abort_res_data", int'(res_data), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_abort", done_cnt, 0);
    check("idle_after_abort", int'(busy), 0);

    run_frame(2, 1'b1, 1'b0, 1'b0, 5050, 8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
